// File: rtl/hilo_forward_unit.sv
// HI/LO forwarding unit for the decode stage.
// Holds the architectural HI/LO registers, forwards the youngest in-flight
// HI/LO value from STAGES pipeline stages, and tracks a single outstanding
// multi-cycle multiply/divide, stalling decode on HI/LO access while the
// result is still pending.
module hilo_forward_unit #(
  parameter int WIDTH   = 32,
  parameter int STAGES  = 3,
  parameter int MAX_LAT = 40,
  parameter int CNT_W   = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [STAGES-1:0]         stage_valid_hi,
  input  logic [STAGES-1:0]         stage_valid_lo,
  input  logic [STAGES*WIDTH-1:0]   stage_hi,
  input  logic [STAGES*WIDTH-1:0]   stage_lo,
  input  logic                      wb_valid_hi,
  input  logic                      wb_valid_lo,
  input  logic [WIDTH-1:0]          wb_hi,
  input  logic [WIDTH-1:0]          wb_lo,
  input  logic                      md_start,
  input  logic                      md_done,
  input  logic [WIDTH-1:0]          md_hi,
  input  logic [WIDTH-1:0]          md_lo,
  input  logic                      md_flush,
  input  logic                      rd_req,
  input  logic                      wr_req,
  output logic [WIDTH-1:0]          vhi,
  output logic [WIDTH-1:0]          vlo,
  output logic                      stall,
  output logic                      md_busy,
  output logic                      md_timeout,
  output logic                      md_err,
  output logic [CNT_W-1:0]          stall_cnt
);

  localparam int LAT_W = $clog2(MAX_LAT + 1);
  localparam logic [LAT_W-1:0] LAT_MAX = LAT_W'(MAX_LAT);

  typedef enum logic {IDLE, BUSY} md_state_t;

  md_state_t        state_reg;
  logic [LAT_W-1:0] lat_cnt_reg;
  logic [WIDTH-1:0] hi_reg;
  logic [WIDTH-1:0] lo_reg;
  logic             md_timeout_reg;
  logic             md_err_reg;
  logic [CNT_W-1:0] stall_cnt_reg;

  // A completion only counts when an op is outstanding and not being flushed;
  // a flushed result is neither forwarded nor committed.
  logic md_ok;
  assign md_ok = (state_reg == BUSY) && md_done && !md_flush;

  // Youngest-first forwarding: walk from the oldest stage to the youngest so
  // the lowest valid index overrides, falling back to md, writeback, register.
  always_comb begin
    vhi = md_ok ? md_hi : (wb_valid_hi ? wb_hi : hi_reg);
    vlo = md_ok ? md_lo : (wb_valid_lo ? wb_lo : lo_reg);
    for (int i = STAGES - 1; i >= 0; i--) begin
      if (stage_valid_hi[i]) vhi = stage_hi[i*WIDTH +: WIDTH];
      if (stage_valid_lo[i]) vlo = stage_lo[i*WIDTH +: WIDTH];
    end
  end

  assign md_busy    = (state_reg == BUSY);
  assign stall      = md_busy && !(md_done && !md_flush) && (rd_req || wr_req);
  assign md_timeout = md_timeout_reg;
  assign md_err     = md_err_reg;
  assign stall_cnt  = stall_cnt_reg;

  // Architectural HI/LO commit; the md result beats a coincident writeback.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi_reg <= '0;
      lo_reg <= '0;
    end else begin
      if (md_ok)            hi_reg <= md_hi;
      else if (wb_valid_hi) hi_reg <= wb_hi;
      if (md_ok)            lo_reg <= md_lo;
      else if (wb_valid_lo) lo_reg <= wb_lo;
    end
  end

  // Multi-cycle op tracker with latency watchdog and sticky error flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= IDLE;
      lat_cnt_reg    <= '0;
      md_timeout_reg <= 1'b0;
      md_err_reg     <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (md_start && !md_flush) begin
            state_reg   <= BUSY;
            lat_cnt_reg <= '0;
          end
        end
        BUSY: begin
          if (md_flush) begin
            state_reg <= IDLE;
          end else if (md_done && md_start) begin
            lat_cnt_reg <= '0;
          end else if (md_done) begin
            state_reg <= IDLE;
          end else if (md_start) begin
            md_err_reg <= 1'b1;
          end else if (lat_cnt_reg != LAT_MAX) begin
            lat_cnt_reg <= lat_cnt_reg + 1'b1;
            if (lat_cnt_reg + 1'b1 == LAT_MAX) md_timeout_reg <= 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Saturating count of cycles decode was held.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_reg <= '0;
    end else if (stall && (stall_cnt_reg != {CNT_W{1'b1}})) begin
      stall_cnt_reg <= stall_cnt_reg + 1'b1;
    end
  end

endmodule
